data_mem_arbiter: RTL and testbench

//  Two-port round-robin arbiter and sequencer for the 256x8 data memory.

---
 rtl/data_mem_arbiter_pkg.sv | 16 +
 rtl/data_mem_arbiter_if.sv | 40 ++++
 rtl/data_mem_arbiter_rr_arb2.sv | 15 +
 rtl/data_mem_arbiter.sv | 87 ++++++++
 tb/tb_data_mem_arbiter.sv | 136 +++++++++++++
 5 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the data memory arbiter.
package data_mem_arb_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester handshakes plus memory pins for the data memory arbiter.
interface data_mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          ack0;
    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          ack1;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    // Arbiter side.
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output ack0, ack1, rdata, busy,
        output mem_we, mem_a, mem_wd,
        input  mem_rd
    );

    // Requesters plus memory side.
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  ack0, ack1, rdata, busy,
        input  mem_we, mem_a, mem_wd,
        output mem_rd
    );
endinterface

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the port
// that was not served last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);
    // Combinational winner selection.
    always_comb begin
        valid = |req;
        if (&req) grant = ~last;
        else      grant = req[1];
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and 3-cycle sequencer in front of the data memory.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    data_mem_arbiter_if.slave bus
);
    arb_state_t    state;
    logic          owner;
    logic          last;
    logic          we_q;
    logic          ack0_q;
    logic          ack1_q;
    logic          busy_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_a_q;
    logic [DW-1:0] mem_wd_q;
    logic [DW-1:0] rdata_q;
    logic          gnt;
    logic          gnt_vld;

    rr_arb2 u_arb (
        .req   ({bus.req1, bus.req0}),
        .last  (last),
        .grant (gnt),
        .valid (gnt_vld)
    );

    // Sequencer FSM; the memory pins come straight from the capture
    // registers so late requester changes never reach the memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= PORT0;
            last     <= PORT1;
            we_q     <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
            mem_we_q <= 1'b0;
            mem_a_q  <= '0;
            mem_wd_q <= '0;
            rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        owner    <= gnt;
                        we_q     <= (gnt == PORT1) ? bus.we1    : bus.we0;
                        mem_we_q <= (gnt == PORT1) ? bus.we1    : bus.we0;
                        mem_a_q  <= (gnt == PORT1) ? bus.addr1  : bus.addr0;
                        mem_wd_q <= (gnt == PORT1) ? bus.wdata1 : bus.wdata0;
                        busy_q   <= 1'b1;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we_q <= 1'b0;
                    if (!we_q) rdata_q <= bus.mem_rd;
                    ack0_q   <= (owner == PORT0);
                    ack1_q   <= (owner == PORT1);
                    state    <= DONE;
                end
                DONE: begin
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                    last   <= owner;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.busy   = busy_q;
    assign bus.rdata  = rdata_q;
    assign bus.mem_we = mem_we_q;
    assign bus.mem_a  = mem_a_q;
    assign bus.mem_wd = mem_wd_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a 256x8 memory model.
module tb_data_mem_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [7:0] mem [256];

    data_mem_arbiter_if #(.AW(8), .DW(8)) bus ();

    data_mem_arbiter #(.AW(8), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word 0 is hard-wired to zero.
    always @(posedge clk) begin
        if (bus.mem_we && bus.mem_a != 8'h00) mem[bus.mem_a] <= bus.mem_wd;
    end
    assign bus.mem_rd = mem[bus.mem_a];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst = 1'b0;
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
        tick(); tick();
        check("reset_outs", {bus.ack0, bus.ack1, bus.busy, bus.mem_we, bus.mem_a, bus.mem_wd, bus.rdata}, 0);
        rst = 1'b1;
        tick();
        check("idle_busy", bus.busy, 0);

        // Single write 0x10 <= 0xA5 from port 0.
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h10; bus.wdata0 = 8'hA5;
        tick();
        check("wr_access", {bus.mem_we, bus.mem_a, bus.mem_wd, bus.busy, bus.ack0}, {1'b1, 8'h10, 8'hA5, 1'b1, 1'b0});
        tick();
        check("wr_ack", {bus.ack0, bus.ack1, bus.mem_we}, 3'b100);
        check("wr_mem", mem[8'h10], 8'hA5);
        bus.req0 = 0;
        tick();
        check("wr_idle", {bus.ack0, bus.busy, bus.mem_we}, 3'b000);

        // Port 1 reads the word back.
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h10;
        tick();
        check("rd_access", {bus.mem_we, bus.mem_a, bus.busy}, {1'b0, 8'h10, 1'b1});
        tick();
        check("rd_ack", {bus.ack1, bus.ack0, bus.rdata}, {1'b1, 1'b0, 8'hA5});
        bus.req1 = 0;
        tick();
        check("rd_hold", {bus.ack1, bus.rdata}, {1'b0, 8'hA5});

        // Contention: port 0 writes 0x30, port 1 reads 0x30, alternating.
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h30; bus.wdata0 = 8'h5A;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h30;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("ct_access", {bus.mem_we, bus.ack0, bus.ack1}, {(k % 2 == 0), 2'b00});
            tick();
            check("ct_ack", {bus.ack0, bus.ack1}, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k % 2 == 1) check("ct_rdata", bus.rdata, 8'h5A);
            tick();
            check("ct_done", {bus.ack0, bus.ack1, bus.busy}, 3'b000);
        end
        bus.req0 = 0; bus.req1 = 0;

        // Late changes ignored; withdrawn request still acked.
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h10; bus.wdata0 = 8'h77;
        tick();
        bus.addr0 = 8'h20; bus.req0 = 0;
        #1;
        check("chg_addr", {bus.mem_a, bus.mem_wd}, {8'h10, 8'h77});
        tick();
        check("chg_ack", bus.ack0, 1'b1);
        tick();
        check("chg_mem", {mem[8'h10], mem[8'h20]}, {8'h77, 8'h00});

        // Address 0 write is forwarded, memory keeps zero.
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h00; bus.wdata0 = 8'hFF;
        tick();
        check("a0_wr", {bus.mem_we, bus.mem_a, bus.mem_wd}, {1'b1, 8'h00, 8'hFF});
        bus.req0 = 0;
        tick(); tick();
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h00;
        tick(); tick();
        check("a0_rd", {bus.ack1, bus.rdata}, {1'b1, 8'h00});
        bus.req1 = 0;
        tick();

        // Reset during a read's ACCESS cycle.
        bus.req1 = 1; bus.addr1 = 8'h10;
        tick();
        check("rst_pre", {bus.busy, bus.mem_a}, {1'b1, 8'h10});
        rst = 1'b0;
        #1;
        check("rst_async", {bus.ack0, bus.ack1, bus.busy, bus.mem_we, bus.mem_a, bus.mem_wd, bus.rdata}, 0);
        tick();
        check("rst_noack", {bus.ack1, bus.rdata}, {1'b0, 8'h00});
        bus.req1 = 0;
        rst = 1'b1;
        tick();

        // First tie after reset goes to port 0.
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h10;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h30;
        tick();
        check("tie_addr", bus.mem_a, 8'h10);
        bus.req0 = 0; bus.req1 = 0;
        tick();
        check("tie_ack", {bus.ack0, bus.ack1, bus.rdata}, {2'b10, 8'h77});
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
